// File: rtl/hazard_pkg.sv
// Shared constants, slot layout and FSM encoding for the MIPS pipeline hazard controller.
package hazard_pkg;

    localparam int REG_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

    // Valid bits live in a separate shift register alongside these slots.
    typedef struct packed {
        logic             regwrite;
        logic             memread;
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             uses_rt;
    } slot_t;

    // MEM/WB-priority operand source select for one EX source register.
    function automatic logic [1:0] fwd_sel(
        input logic             mem_ok,
        input logic [REG_W-1:0] mem_dst,
        input logic             wb_ok,
        input logic [REG_W-1:0] wb_dst,
        input logic [REG_W-1:0] src
    );
        if (mem_ok && mem_dst != '0 && mem_dst == src)
            return FWD_MEM;
        else if (wb_ok && wb_dst != '0 && wb_dst == src)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational register-usage decode of the IF/ID instruction.
module hazard_decode
    import hazard_pkg::*;
(
    input  logic [31:0]      instr,
    input  logic             valid,
    output logic [REG_W-1:0] rs,
    output logic [REG_W-1:0] rt,
    output logic [REG_W-1:0] dst,
    output logic             regwrite,
    output logic             memread,
    output logic             uses_rs,
    output logic             uses_rt
);

    logic [5:0] op;
    logic       unused_instr;

    assign op           = instr[31:26];
    assign unused_instr = ^instr[10:0];

    always_comb begin
        rs       = '0;
        rt       = '0;
        dst      = '0;
        regwrite = 1'b0;
        memread  = 1'b0;
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        if (valid) begin
            unique case (op)
                OP_RTYPE: begin
                    uses_rs  = 1'b1;
                    uses_rt  = 1'b1;
                    dst      = instr[15:11];
                    regwrite = (instr[15:11] != '0);
                end
                OP_LW: begin
                    uses_rs  = 1'b1;
                    dst      = instr[20:16];
                    regwrite = (instr[20:16] != '0);
                    memread  = 1'b1;
                end
                OP_SW, OP_BEQ: begin
                    uses_rs = 1'b1;
                    uses_rt = 1'b1;
                end
                default: ;
            endcase
            // Non-read fields are zeroed so they can never match a destination.
            if (uses_rs) rs = instr[25:21];
            if (uses_rt) rt = instr[20:16];
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctl.sv
// Stall/flush/forwarding controller for a 5-stage MIPS pipeline with a shadow of EX/MEM/WB destinations.
module pipeline_hazard_ctl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             ex_mem_pcsrc,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_bubble,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int STAGES = 2;
    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    logic [STAGES:0]        vld_pipe;
    slot_t [STAGES:0]       slot_q;
    slot_t                  id_slot;
    logic                   id_uses_rs;
    hz_state_e              state_q, state_d;
    logic                   ex_hit, load_use, stall, flush;
    logic                   unused_slot;

    hazard_decode u_decode (
        .instr    (id_instr),
        .valid    (id_valid),
        .rs       (id_slot.rs),
        .rt       (id_slot.rt),
        .dst      (id_slot.dst),
        .regwrite (id_slot.regwrite),
        .memread  (id_slot.memread),
        .uses_rs  (id_uses_rs),
        .uses_rt  (id_slot.uses_rt)
    );

    assign ex_hit = (id_uses_rs && slot_q[EX].dst == id_slot.rs) ||
                    (id_slot.uses_rt && slot_q[EX].dst == id_slot.rt);

    assign load_use = vld_pipe[EX] && slot_q[EX].memread && slot_q[EX].dst != '0 &&
                      id_valid && ex_hit && state_q == ST_RUN;

    // A taken branch squashes the consumer anyway, so it wins over the stall.
    assign flush = ex_mem_pcsrc && !rst;
    assign stall = load_use && !flush && !rst;

    assign pc_stall     = stall;
    assign if_id_stall  = stall;
    assign id_ex_bubble = stall;
    assign flush_if_id  = flush;
    assign flush_id_ex  = flush;
    assign flush_ex_mem = flush;

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!rst) begin
            fwd_a = fwd_sel(vld_pipe[MEM] && slot_q[MEM].regwrite && !slot_q[MEM].memread,
                            slot_q[MEM].dst,
                            vld_pipe[WB] && slot_q[WB].regwrite,
                            slot_q[WB].dst, slot_q[EX].rs);
            if (slot_q[EX].uses_rt)
                fwd_b = fwd_sel(vld_pipe[MEM] && slot_q[MEM].regwrite && !slot_q[MEM].memread,
                                slot_q[MEM].dst,
                                vld_pipe[WB] && slot_q[WB].regwrite,
                                slot_q[WB].dst, slot_q[EX].rt);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (stall) state_d = ST_STALL;
            ST_STALL: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        if (flush) state_d = ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            slot_q   <= '0;
        end else begin
            vld_pipe[WB] <= vld_pipe[MEM];
            slot_q[WB]   <= slot_q[MEM];
            if (flush) begin
                vld_pipe[MEM] <= 1'b0;
                slot_q[MEM]   <= '0;
            end else begin
                vld_pipe[MEM] <= vld_pipe[EX];
                slot_q[MEM]   <= slot_q[EX];
            end
            if (flush || stall) begin
                vld_pipe[EX] <= 1'b0;
                slot_q[EX]   <= '0;
            end else begin
                vld_pipe[EX] <= id_valid;
                slot_q[EX]   <= id_slot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            stall_count <= stall_count + CNT_W'(stall);
            flush_count <= flush_count + CNT_W'(flush);
        end
    end

    assign unused_slot = ^{slot_q[EX].regwrite,
                           slot_q[MEM].rs, slot_q[MEM].rt, slot_q[MEM].uses_rt,
                           slot_q[WB].rs, slot_q[WB].rt, slot_q[WB].uses_rt, slot_q[WB].memread};

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// Directed scoreboard bench for pipeline_hazard_ctl: per-cycle expectations queued by the driver, checked at negedge.
module tb_pipeline_hazard_ctl;

    localparam int CNT_W = 4;

    localparam logic [31:0] LW21   = 32'h8C220000; // lw  $2,0($1)
    localparam logic [31:0] ADD324 = 32'h00441820; // add $3,$2,$4
    localparam logic [31:0] ADD312 = 32'h00221820; // add $3,$1,$2
    localparam logic [31:0] ADD533 = 32'h00632820; // add $5,$3,$3
    localparam logic [31:0] ADD012 = 32'h00220020; // add $0,$1,$2
    localparam logic [31:0] ADD500 = 32'h00002820; // add $5,$0,$0

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      id_instr;
    logic             id_valid;
    logic             ex_mem_pcsrc;
    logic             pc_stall, if_id_stall, id_ex_bubble;
    logic             flush_if_id, flush_id_ex, flush_ex_mem;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_count, flush_count;

    typedef struct packed {
        logic [2:0]       stall;
        logic [2:0]       flush;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    pipeline_hazard_ctl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_instr     (id_instr),
        .id_valid     (id_valid),
        .ex_mem_pcsrc (ex_mem_pcsrc),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .id_ex_bubble (id_ex_bubble),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .flush_ex_mem (flush_ex_mem),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge.
    task automatic step(input logic r, input logic [31:0] ins, input logic v, input logic pc);
        @(posedge clk);
        #1;
        rst          = r;
        id_instr     = ins;
        id_valid     = v;
        ex_mem_pcsrc = pc;
    endtask

    task automatic expect_obs(input string nm, input logic st, input logic fl,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input int sc, input int fc);
        obs_t e;
        e.stall = {3{st}};
        e.flush = {3{fl}};
        e.fa    = fa;
        e.fb    = fb;
        e.sc    = CNT_W'(sc);
        e.fc    = CNT_W'(fc);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e, a;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            a.stall = {pc_stall, if_id_stall, id_ex_bubble};
            a.flush = {flush_if_id, flush_id_ex, flush_ex_mem};
            a.fa    = fwd_a;
            a.fb    = fwd_b;
            a.sc    = stall_count;
            a.fc    = flush_count;
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got stall=%b flush=%b fwd_a=%b fwd_b=%b sc=%0d fc=%0d, want stall=%b flush=%b fwd_a=%b fwd_b=%b sc=%0d fc=%0d",
                         nm, a.stall, a.flush, a.fa, a.fb, a.sc, a.fc,
                         e.stall, e.flush, e.fa, e.fb, e.sc, e.fc);
            end
        end
    end

    initial begin
        rst = 1'b1; id_instr = '0; id_valid = 1'b0; ex_mem_pcsrc = 1'b0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // load-use: lw $2 then add reading $2
        step(0, LW21, 1, 0);    expect_obs("reset_state",   0, 0, 2'b00, 2'b00, 0, 0);
        step(0, ADD324, 1, 0);  expect_obs("lu_stall",      1, 0, 2'b00, 2'b00, 0, 0);
        step(0, ADD324, 1, 0);  expect_obs("lu_release",    0, 0, 2'b00, 2'b00, 1, 0);
        step(0, 0, 0, 0);       expect_obs("lu_fwd_wb",     0, 0, 2'b01, 2'b00, 1, 0);

        // back-to-back ALU dependency forwards from MEM
        step(0, ADD312, 1, 0);  expect_obs("alu_prod_id",   0, 0, 2'b00, 2'b00, 1, 0);
        step(0, ADD533, 1, 0);  expect_obs("alu_prod_ex",   0, 0, 2'b00, 2'b00, 1, 0);
        step(0, 0, 0, 0);       expect_obs("fwd_mem_ab",    0, 0, 2'b10, 2'b10, 1, 0);

        // one-gap dependency forwards from WB; $0 never forwards
        step(0, ADD312, 1, 0);  expect_obs("gap_prod",      0, 0, 2'b00, 2'b00, 1, 0);
        step(0, 0, 0, 0);       expect_obs("gap_nop",       0, 0, 2'b00, 2'b00, 1, 0);
        step(0, ADD533, 1, 0);  expect_obs("gap_cons_id",   0, 0, 2'b00, 2'b00, 1, 0);
        step(0, ADD012, 1, 0);  expect_obs("fwd_wb_ab",     0, 0, 2'b01, 2'b01, 1, 0);
        step(0, ADD500, 1, 0);  expect_obs("r0_writer_ex",  0, 0, 2'b00, 2'b00, 1, 0);
        step(0, ADD312, 1, 0);  expect_obs("r0_no_fwd",     0, 0, 2'b00, 2'b00, 1, 0);

        // branch flush
        step(0, ADD533, 1, 1);  expect_obs("flush_outs",    0, 1, 2'b00, 2'b00, 1, 0);
        step(0, ADD533, 1, 0);  expect_obs("post_flush",    0, 0, 2'b00, 2'b00, 1, 1);
        step(0, 0, 0, 0);       expect_obs("flushed_mem",   0, 0, 2'b00, 2'b00, 1, 1);

        // load-use coinciding with flush: flush only
        step(0, LW21, 1, 0);    expect_obs("lf_load",       0, 0, 2'b00, 2'b00, 1, 1);
        step(0, ADD324, 1, 1);  expect_obs("lf_flush_wins", 0, 1, 2'b00, 2'b00, 1, 1);
        step(0, 0, 0, 0);       expect_obs("lf_after",      0, 0, 2'b00, 2'b00, 1, 2);

        // reset while stalled
        step(0, LW21, 1, 0);    expect_obs("rs_load",       0, 0, 2'b00, 2'b00, 1, 2);
        step(0, ADD324, 1, 0);  expect_obs("rs_stall",      1, 0, 2'b00, 2'b00, 1, 2);
        step(1, ADD324, 1, 0);  expect_obs("rs_in_reset",   0, 0, 2'b00, 2'b00, 2, 2);
        step(0, 0, 0, 0);       expect_obs("rs_cleared",    0, 0, 2'b00, 2'b00, 0, 0);

        // 16 stalls wrap a 4-bit counter back to 0
        for (int k = 0; k < 16; k++) begin
            step(0, LW21, 1, 0);
            expect_obs($sformatf("wrap_load_%0d", k), 0, 0, (k == 0) ? 2'b00 : 2'b01, 2'b00, k, 0);
            step(0, ADD324, 1, 0);
            expect_obs($sformatf("wrap_stall_%0d", k), 1, 0, 2'b00, 2'b00, k, 0);
            step(0, ADD324, 1, 0);
            expect_obs($sformatf("wrap_rel_%0d", k), 0, 0, 2'b00, 2'b00, (k + 1) % 16, 0);
        end
        step(0, 0, 0, 0);       expect_obs("wrap_zero",     0, 0, 2'b01, 2'b00, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
